multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised successor to the 8-bit single-cycle datapath: self-sequenced multicycle core with internal FSM.
//  Drives separate instruction/data memory ports through req/ack handshakes, so wait-state memories are supported.
//  Adds carry/zero flags, relative branches, HALT and illegal-opcode trap. Sits between the memories and the top-level cpu.
// PARAMETERS
//  DATA_W    8  register/ALU/data-memory word width (legal: 8..32)
//  ADDR_W    8  PC and memory address width; PC wraps modulo 2^ADDR_W
//  REG_COUNT 4  general registers (power of 2, 2..16); RA_W = $clog2(REG_COUNT)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  enable       in   1       1 = sequencer may advance; 0 = freeze in current state (held reqs stay high)
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_ack     in   1       fetch data valid this cycle
//  imem_rdata   in   16      instruction word
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1 = store, 0 = load
//  dmem_addr    out  ADDR_W  = low ADDR_W bits of R[rs]
//  dmem_wdata   out  DATA_W  = R[rd]
//  dmem_ack     in   1       access complete (load data valid) this cycle
//  dmem_rdata   in   DATA_W  load data
//  pc_out       out  ADDR_W  current PC
//  result_out   out  DATA_W  last ALU result (registered)
//  flag_z/flag_c out 1       zero / carry flags
//  halted       out  1       in HALT state
//  trap         out  1       in TRAP state (illegal opcode)
// BEHAVIOUR
//  Reset: PC=0, all R=0, result_out=0, flags=0, imem_req=dmem_req=dmem_we=0, halted=trap=0, state=FETCH.
//   Reset mid-handshake drops req asynchronously; late acks after reset are ignored.
//  Format: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm; register fields use low RA_W bits.
//   imm sign-extended to DATA_W (SEXT) or ADDR_W for branches.
//  Ops: 0 NOP | 1 ADD rd+=rs | 2 SUB rd-=rs | 3 AND | 4 OR | 5 XOR | 6 ADDI rd+=SEXT(imm)
//   7 LDI rd=ZEXT(imm) | 8 LD rd=mem[rs] | 9 ST mem[rs]=rd | A BEQZ if R[rd]==0 PC=PC+1+SEXT(imm)
//   B JMP PC=PC+1+SEXT(imm) | C HALT | D-F illegal.
//  Arithmetic modulo 2^DATA_W. C = carry-out (ADD/ADDI) or borrow (SUB); Z = (result==0).
//   Flags update only on ops 1-7; logic ops clear C.
//  FSM: FETCH -> DECODE -> EXEC -> {WB | MEM | FETCH}; MEM -> {WB (LD) | FETCH (ST)}; WB -> FETCH;
//   HALT and TRAP are terminal until reset.
//   FETCH: imem_req=1 until the imem_ack cycle; instruction latched there. Ack allowed in 1st req cycle.
//   DECODE: operands read and latched; C -> HALT; D-F -> TRAP. PC unchanged on both.
//   EXEC: ALU result to result_out; PC=PC+1 (or branch target); NOP/BEQZ/JMP -> FETCH.
//   MEM: dmem_req=1 until dmem_ack; load data latched on ack.
//   WB: R[rd] written (ALU result or load data).
//  req deasserts the cycle after ack; at most one outstanding request per port.
//  Zero-wait cycle counts: ALU/LDI 4, LD 5, ST 4, NOP/BEQZ/JMP 3.
//  enable=0 freezes the FSM; ack arriving while frozen is still captured and acted on when enable returns.
//  PC wrap: 2^ADDR_W-1 +1 -> 0; branch targets also wrap.
//  Same register as rd and rs (e.g. ADD r1,r1) uses pre-instruction values.
// TESTING
//  1. LDI r1,0x05; LDI r2,0x03; ADD r1,r2 -> r1=0x08, Z=0, C=0; result_out=0x08; 12 cycles zero-wait.
//  2. LDI r1,0xFF; ADDI r1,1 -> r1=0x00, Z=1, C=1. Then SUB r1,r2 with r2=1 -> r1=0xFF, C=1 (borrow).
//  3. imem_ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, PC increments once.
//  4. ST r1->[r2=0x10] then LD r3<-[r2] with 2-cycle dmem_ack: dmem_we=1 then 0, addr 0x10, r3=r1.
//  5. BEQZ r0,-2 with r0=0 at PC=0x00 -> PC=0xFF (wrap). With r0!=0 -> PC=0x01.
//  6. Opcode 0xE -> trap=1, PC frozen, no reqs.
//     HALT -> halted=1.
//     reset asserted mid-MEM -> dmem_req=0 immediately, PC=0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle datapath core: self-sequenced FETCH/DECODE/EXEC/MEM/WB engine
// driving separate instruction and data memory ports through req/ack handshakes.
module multicycle_datapath #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned REG_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] result_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted,
    output logic              trap
);

    localparam int unsigned RA_W = $clog2(REG_COUNT);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [15:0]       ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] load_data;
    logic              ack_held;

    // Instruction field decode from the latched instruction word
    logic [3:0]        op;
    logic [RA_W-1:0]   rd_idx;
    logic [RA_W-1:0]   rs_idx;
    logic [7:0]        imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic              is_alu;
    logic              unused_ir;

    assign op        = ir[15:12];
    assign rd_idx    = ir[8 +: RA_W];
    assign rs_idx    = ir[4 +: RA_W];
    assign imm       = ir[7:0];
    assign imm_sext  = DATA_W'($signed(imm));
    assign imm_zext  = DATA_W'(imm);
    assign br_off    = ADDR_W'($signed(imm));
    assign pc_inc    = pc + ADDR_W'(1);
    assign br_target = pc_inc + br_off;
    assign is_alu    = (op >= OP_ADD) && (op <= OP_LDI);
    assign unused_ir = ^ir[11:8];

    assign imem_addr = pc;
    assign pc_out    = pc;

    // ALU: borrow on SUB is simply a < b; logic ops and LDI leave carry clear
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_sum = {1'b0, op_a} + {1'b0, op_b};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_ADDI: begin
                alu_sum = {1'b0, op_a} + {1'b0, imm_sext};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
            end
            OP_LDI:  alu_res = imm_zext;
            default: ;
        endcase
    end

    // Sequencer; an ack seen while frozen is parked in ack_held until enable returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            load_data  <= '0;
            ack_held   <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            result_out <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        if (enable) begin
                            state <= S_DECODE;
                        end else begin
                            ack_held <= 1'b1;
                        end
                    end else if (ack_held) begin
                        if (enable) begin
                            ack_held <= 1'b0;
                            state    <= S_DECODE;
                        end
                    end else if (enable && !imem_req) begin
                        // first fetch after reset raises the request here
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (enable) begin
                        op_a <= regs[rd_idx];
                        op_b <= regs[rs_idx];
                        if (op == OP_HALT) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (op > OP_HALT) begin
                            trap  <= 1'b1;
                            state <= S_TRAP;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (enable) begin
                        if (is_alu) begin
                            pc         <= pc_inc;
                            result_out <= alu_res;
                            flag_z     <= (alu_res == '0);
                            flag_c     <= alu_c;
                            state      <= S_WB;
                        end else if (op == OP_LD || op == OP_ST) begin
                            pc         <= pc_inc;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= ADDR_W'(op_b);
                            dmem_wdata <= op_a;
                            state      <= S_MEM;
                        end else begin
                            if (op == OP_JMP || (op == OP_BEQZ && op_a == '0)) begin
                                pc <= br_target;
                            end else begin
                                pc <= pc_inc;
                            end
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_MEM: begin
                    if ((dmem_req && dmem_ack) || ack_held) begin
                        if (dmem_req) begin
                            dmem_req  <= 1'b0;
                            dmem_we   <= 1'b0;
                            load_data <= dmem_rdata;
                        end
                        if (enable) begin
                            ack_held <= 1'b0;
                            if (op == OP_LD) begin
                                state <= S_WB;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= S_FETCH;
                            end
                        end else begin
                            ack_held <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (enable) begin
                        regs[rd_idx] <= (op == OP_LD) ? load_data : result_out;
                        imem_req     <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_HALT: ;
                S_TRAP: ;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: ISA-level reference model stepped at each fetch
// handshake, randomized wait-state memories and enable gaps, plus directed programs.
module tb_multicycle_datapath;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RC = 4;
    localparam int DMASK = (1 << DW) - 1;
    localparam int AMASK = (1 << AW) - 1;
    localparam int RMASK = RC - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] result_out;
    logic          flag_z;
    logic          flag_c;
    logic          halted;
    logic          trap;

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(DW), .ADDR_W(AW), .REG_COUNT(RC)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .result_out(result_out), .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted), .trap(trap)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] imem [256];
    int env_dmem [256];
    int m_dmem [256];

    // architectural model state
    int m_r [RC];
    int m_pc, m_res, m_z, m_c, m_term;
    int fetches, first_fetch_cyc, last_fetch_cyc, prev_op, have_prev, clean, cyc;
    int exp_d_valid, exp_we, exp_addr, exp_wdata;
    int dut_term_seen;

    // memory responder state
    int i_busy, i_cnt, i_w, i_hi, i_acked, i_len_last;
    int d_busy, d_cnt, d_w, d_hi, d_acked;
    int wait_mode, en_rand;
    int we_log[$];
    int addr_log[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sext8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int exp_cycles(input int op);
        if (op >= 1 && op <= 7) return 4;
        if (op == 8) return 5;
        if (op == 9) return 4;
        return 3;
    endfunction

    function automatic int draw_wait();
        if (wait_mode >= 0) return wait_mode;
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic clear_state();
        for (int i = 0; i < RC; i++) m_r[i] = 0;
        for (int i = 0; i < 256; i++) m_dmem[i] = env_dmem[i];
        m_pc = 0; m_res = 0; m_z = 0; m_c = 0; m_term = 0;
        fetches = 0; first_fetch_cyc = 0; last_fetch_cyc = 0; prev_op = 0;
        have_prev = 0; clean = 0;
        exp_d_valid = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
        dut_term_seen = 0;
        i_busy = 0; i_cnt = 0; i_w = 0; i_hi = 0; i_acked = 0;
        d_busy = 0; d_cnt = 0; d_w = 0; d_hi = 0; d_acked = 0;
        we_log.delete();
        addr_log.delete();
        enable = 1'b1;
    endtask

    // Architectural step at a fetch handshake: check state left by the previous
    // instruction, then execute this one in the model.
    task automatic model_fetch(input int instr);
        int op, rd, rs, imm, a, b, s, res, c;
        chk("fetch_addr", imem_addr, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("result_out", result_out, m_res);
        chk("flag_z", flag_z, m_z);
        chk("flag_c", flag_c, m_c);
        chk("halt_trap_idle", {halted, trap}, 0);
        chk("fetch_after_terminal", m_term, 0);
        chk("dmem_missing", exp_d_valid, 0);
        if (have_prev != 0 && clean != 0) chk("cycle_count", cyc - last_fetch_cyc, exp_cycles(prev_op));
        if (fetches == 0) first_fetch_cyc = cyc;
        fetches++;
        last_fetch_cyc = cyc;
        have_prev = 1;
        clean = int'(enable);
        op  = (instr >> 12) & 15;
        rd  = (instr >> 8) & RMASK;
        rs  = (instr >> 4) & RMASK;
        imm = instr & 255;
        a = m_r[rd];
        b = m_r[rs];
        prev_op = op;
        res = 0; c = 0;
        case (op)
            1: begin s = a + b; res = s & DMASK; c = int'(s > DMASK); end
            2: begin res = (a - b) & DMASK; c = int'(a < b); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: begin s = a + (sext8(imm) & DMASK); res = s & DMASK; c = int'(s > DMASK); end
            7: res = imm;
            default: ;
        endcase
        if (op >= 1 && op <= 7) begin
            m_r[rd] = res; m_res = res; m_z = int'(res == 0); m_c = c;
            m_pc = (m_pc + 1) & AMASK;
        end else if (op == 8 || op == 9) begin
            exp_d_valid = 1; exp_we = int'(op == 9); exp_addr = b & AMASK; exp_wdata = a;
            if (op == 8) m_r[rd] = m_dmem[exp_addr];
            else m_dmem[exp_addr] = a;
            m_pc = (m_pc + 1) & AMASK;
        end else if (op == 0) begin
            m_pc = (m_pc + 1) & AMASK;
        end else if (op == 10) begin
            m_pc = (a == 0) ? ((m_pc + 1 + sext8(imm)) & AMASK) : ((m_pc + 1) & AMASK);
        end else if (op == 11) begin
            m_pc = (m_pc + 1 + sext8(imm)) & AMASK;
        end else if (op == 12) begin
            m_term = 1;
        end else begin
            m_term = 2;
        end
    endtask

    // One clock: sample at the falling edge, compare, then drive the next inputs
    task automatic step();
        @(negedge clk);
        cyc++;
        chk("single_port_active", imem_req & dmem_req, 0);
        if (dut_term_seen != 0) begin
            chk("terminal_no_req", {imem_req, dmem_req}, 0);
            chk("terminal_pc", pc_out, m_pc);
        end
        enable = (en_rand != 0) ? ($urandom_range(0, 4) != 0) : 1'b1;
        if (!enable) clean = 0;

        if (i_acked != 0) begin
            chk("imem_req_drop", imem_req, 0);
            imem_ack = 1'b0;
            i_acked = 0;
        end else if (imem_req) begin
            if (i_busy == 0) begin
                i_busy = 1; i_cnt = draw_wait(); i_w = i_cnt; i_hi = 0;
                if (i_cnt != 0) clean = 0;
            end
            i_hi++;
            chk("imem_addr_hold", imem_addr, m_pc);
            if (i_cnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = imem[imem_addr];
                i_acked = 1; i_busy = 0;
                chk("imem_req_len", i_hi, i_w + 1);
                i_len_last = i_hi;
                model_fetch(int'(imem[imem_addr]));
            end else begin
                i_cnt--;
            end
        end

        if (d_acked != 0) begin
            chk("dmem_req_drop", dmem_req, 0);
            dmem_ack = 1'b0;
            d_acked = 0;
        end else if (dmem_req) begin
            if (d_busy == 0) begin
                d_busy = 1; d_cnt = draw_wait(); d_w = d_cnt; d_hi = 0;
                if (d_cnt != 0) clean = 0;
                chk("dmem_expected", exp_d_valid, 1);
                chk("dmem_we", dmem_we, exp_we);
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_wdata", dmem_wdata, exp_wdata);
                we_log.push_back(int'(dmem_we));
                addr_log.push_back(int'(dmem_addr));
            end
            d_hi++;
            if (d_cnt == 0) begin
                dmem_ack = 1'b1;
                if (dmem_we) env_dmem[dmem_addr] = int'(dmem_wdata);
                else dmem_rdata = DW'(env_dmem[dmem_addr]);
                d_acked = 1; d_busy = 0;
                chk("dmem_req_len", d_hi, d_w + 1);
                exp_d_valid = 0;
            end else begin
                d_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        clear_state();
        @(negedge clk);
        chk("rst_pc", pc_out, 0);
        chk("rst_result", result_out, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);
        chk("rst_reqs", {imem_req, dmem_req, dmem_we}, 0);
        chk("rst_halt_trap", {halted, trap}, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_prog(input int max_fetch);
        int idle = 0;
        int last_f;
        int n = 0;
        while (m_term == 0 && fetches < max_fetch && idle < 300) begin
            last_f = fetches;
            step();
            idle = (fetches == last_f) ? idle + 1 : 0;
        end
        chk("progress", int'(idle < 300), 1);
        if (m_term != 0) begin
            while (!(halted || trap) && n < 60) begin
                step();
                n++;
            end
            chk("halted", halted, int'(m_term == 1));
            chk("trap", trap, int'(m_term == 2));
            chk("terminal_pc_entry", pc_out, m_pc);
            dut_term_seen = 1;
            repeat (5) step();
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic load_random();
        int r, op;
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) op = 12;
            else if (r < 5) op = int'($urandom_range(13, 15));
            else op = int'($urandom_range(0, 11));
            imem[i] = 16'((op << 12) | int'($urandom_range(0, 4095)));
            env_dmem[i] = int'($urandom_range(0, DMASK));
        end
    endtask

    task automatic load_store_prog();
        fill_halt();
        imem[0] = 16'h7210;
        imem[1] = 16'h71A5;
        imem[2] = 16'h9120;
        imem[3] = 16'h8320;
        imem[4] = 16'h9300;
        imem[5] = 16'hC000;
        env_dmem[8'h10] = 0;
        env_dmem[0] = 0;
    endtask

    task automatic check_load_store(input string tag);
        chk({tag, "_n_access"}, we_log.size(), 3);
        if (we_log.size() == 3) begin
            chk({tag, "_we0"}, we_log[0], 1);
            chk({tag, "_we1"}, we_log[1], 0);
            chk({tag, "_we2"}, we_log[2], 1);
            chk({tag, "_addr0"}, addr_log[0], 8'h10);
            chk({tag, "_addr1"}, addr_log[1], 8'h10);
            chk({tag, "_addr2"}, addr_log[2], 8'h00);
        end
        chk({tag, "_mem10"}, env_dmem[8'h10], 8'hA5);
        chk({tag, "_mem00"}, env_dmem[0], 8'hA5);
        chk({tag, "_model_r3"}, m_r[3], 8'hA5);
    endtask

    initial begin
        #1500000;
        $display("FAIL global_timeout: reached %0t without finishing", $time);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        i_len_last = 0;
        imem_rdata = '0;
        dmem_rdata = '0;
        for (int i = 0; i < 256; i++) env_dmem[i] = 0;
        wait_mode = 0;
        en_rand = 0;

        // LDI/LDI/ADD, zero wait
        fill_halt();
        imem[0] = 16'h7105; imem[1] = 16'h7203; imem[2] = 16'h1120;
        do_reset();
        run_prog(50);
        chk("t1_result", result_out, 8'h08);
        chk("t1_flags", {flag_z, flag_c}, 2'b00);
        chk("t1_pc", pc_out, 3);
        chk("t1_cycles", last_fetch_cyc - first_fetch_cyc, 12);
        chk("t1_model_res", m_res, 8'h08);

        // ADDI overflow to zero
        fill_halt();
        imem[0] = 16'h7201; imem[1] = 16'h71FF; imem[2] = 16'h6101;
        do_reset();
        run_prog(50);
        chk("t2a_result", result_out, 8'h00);
        chk("t2a_zc", {flag_z, flag_c}, 2'b11);

        // SUB borrow
        imem[3] = 16'h2120;
        do_reset();
        run_prog(50);
        chk("t2b_result", result_out, 8'hFF);
        chk("t2b_zc", {flag_z, flag_c}, 2'b01);
        chk("t2b_model_c", m_c, 1);

        // Fetch with 3 wait states
        fill_halt();
        imem[0] = 16'h7105; imem[1] = 16'h7203; imem[2] = 16'h1120;
        wait_mode = 3;
        do_reset();
        run_prog(50);
        chk("t3_req_len", i_len_last, 4);
        chk("t3_result", result_out, 8'h08);

        // Store then load with 2-cycle data ack
        load_store_prog();
        wait_mode = 2;
        do_reset();
        run_prog(50);
        check_load_store("t4");

        // BEQZ taken with PC wrap
        wait_mode = 0;
        fill_halt();
        imem[0] = 16'hA0FE;
        do_reset();
        run_prog(50);
        chk("t5a_pc", pc_out, 8'hFF);
        chk("t5a_halted", halted, 1);

        // BEQZ not taken
        fill_halt();
        imem[0] = 16'h7001; imem[1] = 16'hA0FE;
        do_reset();
        run_prog(50);
        chk("t5b_pc", pc_out, 8'h02);

        // Illegal opcode
        fill_halt();
        imem[0] = 16'hE000;
        do_reset();
        run_prog(50);
        chk("t6_trap", trap, 1);
        chk("t6_halted", halted, 0);
        chk("t6_pc", pc_out, 0);

        // Reset during a data access, with stale acks held across release
        load_store_prog();
        wait_mode = 3;
        do_reset();
        begin
            int n = 0;
            while (!dmem_req && n < 100) begin
                step();
                n++;
            end
            chk("t7_reached_mem", dmem_req, 1);
        end
        reset = 1'b0;
        #1;
        chk("t7_async_dmem_req", dmem_req, 0);
        chk("t7_async_pc", pc_out, 0);
        chk("t7_async_imem_req", imem_req, 0);
        clear_state();
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        imem_rdata = 16'hE000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_late_ack_trap", trap, 0);
        chk("t7_late_ack_pc", pc_out, 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        wait_mode = -1;
        run_prog(50);
        check_load_store("t7");

        // Random programs with wait states and enable gaps
        wait_mode = -1;
        en_rand = 1;
        for (int p = 0; p < 25; p++) begin
            load_random();
            do_reset();
            run_prog(60);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
